// File: rtl/hdmi_pcie_width_fifo.sv
// Single-clock width-converting FIFO: 16-bit HDMI pixel words in, 128-bit PCIe DMA beats out.
// Seven write words are staged in a shift register. The eighth completes a read word in the RAM.
module hdmi_pcie_width_fifo #(
    parameter int unsigned WR_DEPTH_WIDTH   = 15,
    parameter int unsigned WR_DATA_WIDTH    = 16,
    parameter int unsigned RD_DEPTH_WIDTH   = 12,
    parameter int unsigned RD_DATA_WIDTH    = 128,
    parameter int unsigned ALMOST_FULL_NUM  = 1020,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    input  logic                      rd_en,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam int unsigned R_LOG2    = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
    localparam int unsigned RATIO     = 1 << R_LOG2;
    localparam int unsigned CW        = WR_DEPTH_WIDTH + 1;
    localparam int unsigned PW        = RD_DEPTH_WIDTH + 1;
    localparam int unsigned CAP       = 1 << WR_DEPTH_WIDTH;
    localparam int unsigned RAM_DEPTH = 1 << RD_DEPTH_WIDTH;
    localparam int unsigned PACK_W    = WR_DATA_WIDTH * (RATIO - 1);

    logic [RD_DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [PACK_W-1:0]        r_pack;
    logic [CW-1:0]            r_count;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW-1:0]            r_rd_level;
    logic                     r_wr_full;
    logic                     r_almost_full;
    logic                     r_rd_empty;
    logic                     r_almost_empty;
    logic [RD_DATA_WIDTH-1:0] r_rd_data;

    logic [R_LOG2-1:0]        w_sub;
    logic                     w_wr_acc;
    logic                     w_rd_acc;
    logic                     w_pack_done;
    logic [CW-1:0]            w_count_nxt;
    logic [PW-1:0]            w_wr_ptr_nxt;
    logic [PW-1:0]            w_rd_ptr_nxt;
    logic [PW-1:0]            w_rd_level_nxt;

    // Accept decisions and next occupancy, pointer and level values.
    // The low count bits equal the number of staged words, because a read always removes a whole multiple of RATIO.
    always_comb begin
        w_sub          = r_count[R_LOG2-1:0];
        w_wr_acc       = wr_en & ~r_wr_full;
        w_rd_acc       = rd_en & ~r_rd_empty;
        w_pack_done    = w_wr_acc && (w_sub == R_LOG2'(RATIO - 1));
        w_count_nxt    = r_count + (w_wr_acc ? CW'(1) : CW'(0))
                                 - (w_rd_acc ? CW'(RATIO) : CW'(0));
        w_wr_ptr_nxt   = r_wr_ptr + (w_pack_done ? PW'(1) : PW'(0));
        w_rd_ptr_nxt   = r_rd_ptr + (w_rd_acc ? PW'(1) : PW'(0));
        w_rd_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    // Completed words go to the RAM. The RAM has no reset so it can infer as a block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && w_pack_done) begin
            r_mem[r_wr_ptr[PW-2:0]] <= {wr_data, r_pack};
        end
    end

    // Control state, staging shift register, registered flags and read data. Reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pack         <= '0;
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rd_level     <= '0;
            r_wr_full      <= 1'b0;
            r_almost_full  <= 1'b0;
            r_rd_empty     <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_data      <= '0;
        end else begin
            if (w_wr_acc && !w_pack_done) begin
                r_pack <= {wr_data, r_pack[PACK_W-1:WR_DATA_WIDTH]};
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr[PW-2:0]];
            end
            r_count        <= w_count_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_rd_level     <= w_rd_level_nxt;
            r_wr_full      <= (w_count_nxt == CW'(CAP));
            r_almost_full  <= (w_count_nxt >= CW'(ALMOST_FULL_NUM));
            r_rd_empty     <= (w_rd_level_nxt == PW'(0));
            r_almost_empty <= (w_rd_level_nxt <= PW'(ALMOST_EMPTY_NUM));
        end
    end

    assign wr_full        = r_wr_full;
    assign wr_water_level = r_count;
    assign almost_full    = r_almost_full;
    assign rd_data        = r_rd_data;
    assign rd_empty       = r_rd_empty;
    assign rd_water_level = r_rd_level;
    assign almost_empty   = r_almost_empty;

endmodule

// File: tb/tb_hdmi_pcie_width_fifo.sv
// Directed bench for hdmi_pcie_width_fifo: reset, packing, partial words, thresholds, full, simultaneous access, mid-stream reset.
module tb_hdmi_pcie_width_fifo;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   wr_data;
    logic          wr_en;
    logic          wr_full;
    logic [15:0]   wr_water_level;
    logic          almost_full;
    logic [127:0]  rd_data;
    logic          rd_en;
    logic          rd_empty;
    logic [12:0]   rd_water_level;
    logic          almost_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    hdmi_pcie_width_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    always #5 clk = ~clk;

    // Build an expected read word whose write word k equals base + step*k.
    function automatic logic [127:0] pack8(input int base, input int step);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = 16'(base + step * k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_levels(input string tag, input int wl, input int rl);
        chk({tag, "_wlvl"}, 128'(wr_water_level), 128'(wl));
        chk({tag, "_rlvl"}, 128'(rd_water_level), 128'(rl));
    endtask

    initial begin
        logic [127:0] held;

        // Reset held for three edges while both requests are active
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'hABCD;
        repeat (3) tick();
        chk("rst_full",    128'(wr_full),      128'(0));
        chk("rst_afull",   128'(almost_full),  128'(0));
        chk("rst_empty",   128'(rd_empty),     128'(1));
        chk("rst_aempty",  128'(almost_empty), 128'(1));
        chk("rst_rdata",   rd_data,            128'(0));
        chk_levels("rst", 0, 0);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk_levels("rst_post", 0, 0);

        // Packing of eight words, first write in the LSBs
        for (int i = 1; i <= 7; i++) wr(16'(i));
        chk("pk_empty7", 128'(rd_empty), 128'(1));
        wr(16'h0008);
        chk("pk_empty8", 128'(rd_empty), 128'(0));
        chk_levels("pk8", 8, 1);
        rd();
        chk("pk_rdata", rd_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("pk_empty_after", 128'(rd_empty), 128'(1));
        chk_levels("pk_after", 0, 0);

        // A partial word is never readable and rd_data holds
        for (int i = 0; i < 7; i++) wr(16'(16'h0101 + i));
        rd();
        chk("pt_empty", 128'(rd_empty), 128'(1));
        chk("pt_rdata", rd_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk_levels("pt", 7, 0);

        // Thresholds
        for (int i = 7; i < 40; i++) wr(16'(16'h0101 + i));
        chk_levels("th40", 40, 5);
        chk("th40_aempty", 128'(almost_empty), 128'(0));
        rd();
        chk("th_rd_data", rd_data, pack8(16'h0101, 1));
        chk("th32_aempty", 128'(almost_empty), 128'(1));
        chk_levels("th32", 32, 4);
        for (int i = 32; i < 1019; i++) wr(16'(i));
        chk("th1019_lvl",   128'(wr_water_level), 128'(1019));
        chk("th1019_afull", 128'(almost_full),    128'(0));
        wr(16'h03FB);
        chk("th1020_lvl",   128'(wr_water_level), 128'(1020));
        chk("th1020_afull", 128'(almost_full),    128'(1));

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_levels("th_rst", 0, 0);

        // Fill completely with decrementing words starting at 0xFFFF
        for (int i = 0; i < 32768; i++) wr(16'(65535 - i));
        chk("fl_full", 128'(wr_full), 128'(1));
        chk("fl_afull", 128'(almost_full), 128'(1));
        chk("fl_empty", 128'(rd_empty), 128'(0));
        chk_levels("fl", 32768, 4096);
        wr(16'h1234);
        chk("fl_extra_lvl", 128'(wr_water_level), 128'(32768));
        chk("fl_extra_full", 128'(wr_full), 128'(1));
        for (int j = 0; j < 4096; j++) begin
            rd();
            chk($sformatf("fl_rd%0d", j), rd_data, pack8(65535 - 8 * j, -1));
            if (j == 0) begin
                chk("fl_first", rd_data, 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF);
                chk("fl_notfull", 128'(wr_full), 128'(0));
                chk_levels("fl_rd0", 32760, 4095);
            end
        end
        chk("fl_last", rd_data, 128'h8000_8001_8002_8003_8004_8005_8006_8007);
        chk("fl_drained_empty", 128'(rd_empty), 128'(1));
        chk("fl_drained_aempty", 128'(almost_empty), 128'(1));
        chk_levels("fl_drained", 0, 0);
        held = rd_data;
        rd();
        chk("fl_hold", rd_data, held);

        // Simultaneous write and read with 16 words stored
        for (int i = 0; i < 16; i++) wr(16'(16'h0A00 + i));
        chk_levels("sm16", 16, 2);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'h0A10;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_levels("sm9", 9, 1);
        chk("sm_rd0", rd_data, pack8(16'h0A00, 1));
        for (int i = 17; i < 24; i++) wr(16'(16'h0A00 + i));
        chk_levels("sm16b", 16, 2);
        rd();
        chk("sm_rd1", rd_data, pack8(16'h0A08, 1));
        rd();
        chk("sm_rd2", rd_data, pack8(16'h0A10, 1));
        chk_levels("sm_end", 0, 0);

        // Mid-stream reset drops complete and partial words
        for (int i = 0; i < 11; i++) wr(16'(16'h0B00 + i));
        rst_n = 1'b0;
        wr_en = 1'b1;
        wr_data = 16'h0BFF;
        tick();
        rst_n = 1'b1;
        wr_en = 1'b0;
        chk_levels("mr", 0, 0);
        chk("mr_empty", 128'(rd_empty), 128'(1));
        chk("mr_rdata", rd_data, 128'(0));
        for (int i = 0; i < 8; i++) wr(16'(16'h0C00 + i));
        rd();
        chk("mr_clean_word", rd_data, pack8(16'h0C00, 1));
        chk_levels("mr_end", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_pcie_width_fifo.md
Name: hdmi_pcie_width_fifo

Overview:
- Single-clock, width-converting FIFO between the HDMI capture path (16-bit pixel words) and the PCIe DMA path (128-bit beats).
- Packs eight consecutive 16-bit writes into one 128-bit read word.
- Provides full/empty flags, exact water levels and programmable almost-full/almost-empty flags.

Parameters:
- WR_DEPTH_WIDTH, 15: log2 of capacity in write words (32768).
- WR_DATA_WIDTH, 16: write word width.
- RD_DEPTH_WIDTH, 12: log2 of capacity in read words (4096).
- RD_DATA_WIDTH, 128: read word width. Must equal WR_DATA_WIDTH * 2^(WR_DEPTH_WIDTH-RD_DEPTH_WIDTH); ratio R = 8.
- ALMOST_FULL_NUM, 1020: almost_full threshold, in write words.
- ALMOST_EMPTY_NUM, 4: almost_empty threshold, in read words.

Ports:
- clk  in  1  single clock for both sides; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_data  in  WR_DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds 2^WR_DEPTH_WIDTH write words.
- wr_water_level  out  WR_DEPTH_WIDTH+1  stored write words.
- almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM.
- rd_data  out  RD_DATA_WIDTH  read data.
- rd_en  in  1  read request.
- rd_empty  out  1  fewer than R write words stored (no complete read word).
- rd_water_level  out  RD_DEPTH_WIDTH+1  complete read words stored = floor(wr_water_level/R).
- almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears pointers and counters.
- Outputs after reset:
  - wr_full=0, almost_full=0, wr_water_level=0
  - rd_empty=1, almost_empty=1, rd_water_level=0
  - rd_data=0
- Reset mid-operation discards all contents, including any partially packed word. rst_n=0 has priority over wr_en and rd_en.
- Write: on an edge with wr_en=1 and wr_full=0, wr_data is stored and the write count increments. Writes while full are ignored; there is no error output.
- Packing: the write words of one read word are numbered 0..7 in arrival order. Word k goes to rd_data[16k+15:16k], so the first-written word occupies the LSBs.
- Read: on an edge with rd_en=1 and rd_empty=0, the oldest complete 128-bit word is popped.
  - rd_data updates at that same edge, giving a 1-cycle latency from rd_en sampled to data valid.
  - rd_data holds its value until the next accepted read.
  - Reads while empty are ignored, and rd_data holds.
- Partial words (fewer than 8 pending writes) are never readable.
- Occupancy is tracked in write-word units, count range 0..2^WR_DEPTH_WIDTH:
  - accepted write: +1
  - accepted read: -R
  - write and read accepted on the same edge: +1-R
- Flags and levels are registered and reflect occupancy after each edge, with no synchronizer latency since there is one clock:
  - wr_full = (count == 2^WR_DEPTH_WIDTH)
  - rd_empty = (count < R)
- Pointers wrap modulo depth. The extra MSB distinguishes full from empty.
- Storage is an inferred RAM. There is no dependency on vendor global-reset primitives.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with wr_en=1 and rd_en=1 -> all outputs at reset values, nothing stored.
- Packing: write 0x0001..0x0008, then pulse rd_en -> after the 8th write rd_empty=0 and rd_water_level=1; one cycle after the read rd_data=0x0008_0007_0006_0005_0004_0003_0002_0001; rd_empty=1 and wr_water_level=0 after the read.
- Partial: write 7 words and assert rd_en -> rd_empty stays 1, rd_data unchanged, wr_water_level=7.
- Thresholds:
  - After 40 writes: rd_water_level=5, almost_empty=0.
  - Read 1 word: almost_empty=1.
  - Write up to 1019 stored: almost_full=0; at 1020 stored: almost_full=1.
- Full: write 32768 decrementing words from 0xFFFF -> wr_full=1, wr_water_level=32768, rd_water_level=4096. A 32769th write is ignored. Reading all 4096 words returns the data in order; the first word is 0xFFF8_FFF9_..._FFFF and rd_empty=1 at the end.
- Simultaneous: with 16 words stored, assert wr_en and rd_en on the same edge -> wr_water_level=9, data order preserved. Then mid-stream rst_n=0 -> all levels 0 and rd_empty=1.
